// File: rtl/id_ex_stage.sv
// Decode stage of the pipelined OTTER core: field extraction, immediate generation,
// writeback bypass, load-use hazard detection and the ID/EX pipeline register.
module id_ex_stage (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IF_ID_INSTR,
   input  logic [31:0] IF_ID_PC,
   input  logic        IF_ID_VALID,
   input  logic [31:0] RD1,
   input  logic [31:0] RD2,
   input  logic        WB_WE,
   input  logic [4:0]  WB_RD,
   input  logic [31:0] WB_DATA,
   input  logic        EX_FLUSH,
   output logic [4:0]  A1,
   output logic [4:0]  A2,
   output logic        STALL,
   output logic        ID_EX_VALID,
   output logic [31:0] ID_EX_PC,
   output logic [31:0] ID_EX_RS1_DATA,
   output logic [31:0] ID_EX_RS2_DATA,
   output logic [31:0] ID_EX_IMM,
   output logic [4:0]  ID_EX_RS1,
   output logic [4:0]  ID_EX_RS2,
   output logic [4:0]  ID_EX_RD,
   output logic [6:0]  ID_EX_OPCODE,
   output logic [2:0]  ID_EX_FUNCT3,
   output logic        ID_EX_FUNCT7B5,
   output logic        ID_EX_REGWRITE,
   output logic        ID_EX_MEMREAD,
   output logic        ID_EX_MEMWRITE
);

   typedef enum logic [2:0] {FMT_ILL, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

   logic [31:0] instr;
   logic [4:0]  rs1, rs2, rd;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   fmt_t        fmt;
   logic [31:0] imm;
   logic        uses_rs1, uses_rs2, regwrite;
   logic [31:0] rs1_data, rs2_data;
   logic        hazard, load_en;

   logic        valid_q, valid_d;
   logic [31:0] pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
   logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [6:0]  opcode_q, opcode_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        funct7b5_q, funct7b5_d;
   logic        regwrite_q, regwrite_d, memread_q, memread_d, memwrite_q, memwrite_d;

   assign instr  = IF_ID_INSTR;
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign rd     = instr[11:7];
   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign A1     = rs1;
   assign A2     = rs2;

   always_comb begin
      fmt = FMT_ILL;
      case (opcode)
         7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
         7'b0100011:                         fmt = FMT_S;
         7'b1100011:                         fmt = FMT_B;
         7'b0110111, 7'b0010111:             fmt = FMT_U;
         7'b1101111:                         fmt = FMT_J;
         7'b0110011:                         fmt = FMT_R;
         default:                            fmt = FMT_ILL;
      endcase
   end

   always_comb begin
      imm = 32'd0;
      case (fmt)
         FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm = {instr[31:12], 12'd0};
         FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = 32'd0;
      endcase
   end

   assign regwrite = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
   assign uses_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
   assign uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

   // The register file writes on the same edge we capture, so forward WB data here.
   always_comb begin
      rs1_data = RD1;
      rs2_data = RD2;
      if (WB_WE && (WB_RD != 5'd0) && (WB_RD == rs1)) rs1_data = WB_DATA;
      if (WB_WE && (WB_RD != 5'd0) && (WB_RD == rs2)) rs2_data = WB_DATA;
      if (rs1 == 5'd0) rs1_data = 32'd0;
      if (rs2 == 5'd0) rs2_data = 32'd0;
   end

   assign hazard = valid_q && memread_q && (rd_q != 5'd0) && IF_ID_VALID &&
                   ((uses_rs1 && (rd_q == rs1)) || (uses_rs2 && (rd_q == rs2)));
   assign STALL   = hazard && !EX_FLUSH && !RST;
   assign load_en = IF_ID_VALID && !EX_FLUSH && !hazard;

   always_comb begin
      valid_d    = 1'b0;
      pc_d       = 32'd0;
      rs1_data_d = 32'd0;
      rs2_data_d = 32'd0;
      imm_d      = 32'd0;
      rs1_d      = 5'd0;
      rs2_d      = 5'd0;
      rd_d       = 5'd0;
      opcode_d   = 7'd0;
      funct3_d   = 3'd0;
      funct7b5_d = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      if (load_en) begin
         valid_d    = 1'b1;
         pc_d       = IF_ID_PC;
         rs1_data_d = rs1_data;
         rs2_data_d = rs2_data;
         imm_d      = imm;
         rs1_d      = rs1;
         rs2_d      = rs2;
         rd_d       = rd;
         opcode_d   = opcode;
         funct3_d   = funct3;
         funct7b5_d = instr[30];
         regwrite_d = regwrite;
         memread_d  = (opcode == 7'b0000011);
         memwrite_d = (opcode == 7'b0100011);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid_q    <= 1'b0;
         pc_q       <= 32'd0;
         rs1_data_q <= 32'd0;
         rs2_data_q <= 32'd0;
         imm_q      <= 32'd0;
         rs1_q      <= 5'd0;
         rs2_q      <= 5'd0;
         rd_q       <= 5'd0;
         opcode_q   <= 7'd0;
         funct3_q   <= 3'd0;
         funct7b5_q <= 1'b0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         opcode_q   <= opcode_d;
         funct3_q   <= funct3_d;
         funct7b5_q <= funct7b5_d;
         regwrite_q <= regwrite_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
      end
   end

   assign ID_EX_VALID    = valid_q;
   assign ID_EX_PC       = pc_q;
   assign ID_EX_RS1_DATA = rs1_data_q;
   assign ID_EX_RS2_DATA = rs2_data_q;
   assign ID_EX_IMM      = imm_q;
   assign ID_EX_RS1      = rs1_q;
   assign ID_EX_RS2      = rs2_q;
   assign ID_EX_RD       = rd_q;
   assign ID_EX_OPCODE   = opcode_q;
   assign ID_EX_FUNCT3   = funct3_q;
   assign ID_EX_FUNCT7B5 = funct7b5_q;
   assign ID_EX_REGWRITE = regwrite_q;
   assign ID_EX_MEMREAD  = memread_q;
   assign ID_EX_MEMWRITE = memwrite_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, bypass, load-use, flush, formats and async reset.
module tb_id_ex_stage;

   logic        CLK, RST;
   logic [31:0] IF_ID_INSTR, IF_ID_PC;
   logic        IF_ID_VALID;
   logic [31:0] RD1, RD2;
   logic        WB_WE;
   logic [4:0]  WB_RD;
   logic [31:0] WB_DATA;
   logic        EX_FLUSH;
   logic [4:0]  A1, A2;
   logic        STALL, ID_EX_VALID;
   logic [31:0] ID_EX_PC, ID_EX_RS1_DATA, ID_EX_RS2_DATA, ID_EX_IMM;
   logic [4:0]  ID_EX_RS1, ID_EX_RS2, ID_EX_RD;
   logic [6:0]  ID_EX_OPCODE;
   logic [2:0]  ID_EX_FUNCT3;
   logic        ID_EX_FUNCT7B5, ID_EX_REGWRITE, ID_EX_MEMREAD, ID_EX_MEMWRITE;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [31:0] ADDI    = 32'hFFC0_8293; // addi x5,x1,-4
   localparam logic [31:0] ADD_BP  = 32'h0020_81B3; // add x3,x1,x2
   localparam logic [31:0] ADD_X0  = 32'h0020_01B3; // add x3,x0,x2
   localparam logic [31:0] LW      = 32'h0001_2383; // lw x7,0(x2)
   localparam logic [31:0] ADD_DEP = 32'h0013_8433; // add x8,x7,x1
   localparam logic [31:0] ADD_IND = 32'h0010_8433; // add x8,x1,x1
   localparam logic [31:0] SW_M1   = 32'hFE20_AFA3; // sw x2,-1(x1)
   localparam logic [31:0] BEQ_M2  = 32'hFE20_8FE3; // beq x1,x2,-2
   localparam logic [31:0] LUI_F   = 32'hFFFF_F2B7; // lui x5,0xFFFFF
   localparam logic [31:0] JAL_M2  = 32'hFFFF_F0EF; // jal x1,-2
   localparam logic [31:0] ILLEGAL = 32'hFFFF_FFFF;

   id_ex_stage dut (
      .CLK(CLK), .RST(RST),
      .IF_ID_INSTR(IF_ID_INSTR), .IF_ID_PC(IF_ID_PC), .IF_ID_VALID(IF_ID_VALID),
      .RD1(RD1), .RD2(RD2),
      .WB_WE(WB_WE), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
      .EX_FLUSH(EX_FLUSH),
      .A1(A1), .A2(A2), .STALL(STALL),
      .ID_EX_VALID(ID_EX_VALID), .ID_EX_PC(ID_EX_PC),
      .ID_EX_RS1_DATA(ID_EX_RS1_DATA), .ID_EX_RS2_DATA(ID_EX_RS2_DATA),
      .ID_EX_IMM(ID_EX_IMM),
      .ID_EX_RS1(ID_EX_RS1), .ID_EX_RS2(ID_EX_RS2), .ID_EX_RD(ID_EX_RD),
      .ID_EX_OPCODE(ID_EX_OPCODE), .ID_EX_FUNCT3(ID_EX_FUNCT3),
      .ID_EX_FUNCT7B5(ID_EX_FUNCT7B5),
      .ID_EX_REGWRITE(ID_EX_REGWRITE), .ID_EX_MEMREAD(ID_EX_MEMREAD),
      .ID_EX_MEMWRITE(ID_EX_MEMWRITE)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic valid);
      IF_ID_INSTR = instr;
      IF_ID_PC    = pc;
      IF_ID_VALID = valid;
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_vec({tag, "_valid"}, {31'd0, ID_EX_VALID}, 32'd0);
      check_vec({tag, "_pc"}, ID_EX_PC, 32'd0);
      check_vec({tag, "_rs1d"}, ID_EX_RS1_DATA, 32'd0);
      check_vec({tag, "_rs2d"}, ID_EX_RS2_DATA, 32'd0);
      check_vec({tag, "_imm"}, ID_EX_IMM, 32'd0);
      check_vec({tag, "_regs"}, {17'd0, ID_EX_RS1, ID_EX_RS2, ID_EX_RD}, 32'd0);
      check_vec({tag, "_fields"}, {21'd0, ID_EX_OPCODE, ID_EX_FUNCT3, ID_EX_FUNCT7B5}, 32'd0);
      check_vec({tag, "_ctl"}, {29'd0, ID_EX_REGWRITE, ID_EX_MEMREAD, ID_EX_MEMWRITE}, 32'd0);
      check_vec({tag, "_stall"}, {31'd0, STALL}, 32'd0);
   endtask

   initial begin
      RST = 1'b1;
      IF_ID_INSTR = 32'd0; IF_ID_PC = 32'd0; IF_ID_VALID = 1'b0;
      RD1 = 32'd0; RD2 = 32'd0;
      WB_WE = 1'b0; WB_RD = 5'd0; WB_DATA = 32'd0;
      EX_FLUSH = 1'b0;
      #2;
      check_all_zero("reset");
      tick();
      tick();
      RST = 1'b0;

      // addi x5,x1,-4
      RD1 = 32'd10;
      drive(ADDI, 32'h100, 1'b1);
      check_vec("addi_a1", {27'd0, A1}, 32'd1);
      check_vec("addi_a2", {27'd0, A2}, 32'd28);
      check_vec("addi_stall", {31'd0, STALL}, 32'd0);
      tick();
      check_vec("addi_imm", ID_EX_IMM, 32'hFFFF_FFFC);
      check_vec("addi_rd", {27'd0, ID_EX_RD}, 32'd5);
      check_vec("addi_rs1d", ID_EX_RS1_DATA, 32'd10);
      check_vec("addi_ctl", {28'd0, ID_EX_VALID, ID_EX_REGWRITE, ID_EX_MEMREAD, ID_EX_MEMWRITE}, 32'b1100);
      check_vec("addi_pc", ID_EX_PC, 32'h100);
      check_vec("addi_op", {22'd0, ID_EX_OPCODE, ID_EX_FUNCT3}, {22'd0, 7'b0010011, 3'd0});

      // writeback bypass
      RD1 = 32'd0; RD2 = 32'h55;
      WB_WE = 1'b1; WB_RD = 5'd1; WB_DATA = 32'hDEAD_BEEF;
      drive(ADD_BP, 32'h104, 1'b1);
      tick();
      check_vec("byp_rs1d", ID_EX_RS1_DATA, 32'hDEAD_BEEF);
      check_vec("byp_rs2d", ID_EX_RS2_DATA, 32'h55);
      check_vec("byp_imm", ID_EX_IMM, 32'd0);
      WB_RD = 5'd0; RD1 = 32'h1234;
      drive(ADD_BP, 32'h108, 1'b1);
      tick();
      check_vec("byp_wbx0_rs1d", ID_EX_RS1_DATA, 32'h1234);
      RD1 = 32'h999; WB_RD = 5'd0;
      drive(ADD_X0, 32'h10C, 1'b1);
      tick();
      check_vec("x0_rs1d", ID_EX_RS1_DATA, 32'd0);
      WB_WE = 1'b0;

      // load-use with dependency
      drive(LW, 32'h200, 1'b1);
      tick();
      check_vec("lw_memread", {31'd0, ID_EX_MEMREAD}, 32'd1);
      check_vec("lw_rd", {27'd0, ID_EX_RD}, 32'd7);
      drive(ADD_DEP, 32'h204, 1'b1);
      check_vec("lu_stall", {31'd0, STALL}, 32'd1);
      tick();
      check_vec("lu_bubble", {31'd0, ID_EX_VALID}, 32'd0);
      check_vec("lu_bubble_ctl", {29'd0, ID_EX_REGWRITE, ID_EX_MEMREAD, ID_EX_MEMWRITE}, 32'd0);
      check_vec("lu_stall_clr", {31'd0, STALL}, 32'd0);
      tick();
      check_vec("lu_issue_valid", {31'd0, ID_EX_VALID}, 32'd1);
      check_vec("lu_issue_rd", {27'd0, ID_EX_RD}, 32'd8);
      check_vec("lu_issue_pc", ID_EX_PC, 32'h204);

      // load followed by independent add
      drive(LW, 32'h300, 1'b1);
      tick();
      drive(ADD_IND, 32'h304, 1'b1);
      check_vec("nodep_stall", {31'd0, STALL}, 32'd0);
      tick();
      check_vec("nodep_valid", {31'd0, ID_EX_VALID}, 32'd1);
      check_vec("nodep_pc", ID_EX_PC, 32'h304);

      // flush during hazard
      drive(LW, 32'h400, 1'b1);
      tick();
      EX_FLUSH = 1'b1;
      drive(ADD_DEP, 32'h404, 1'b1);
      check_vec("flush_stall", {31'd0, STALL}, 32'd0);
      tick();
      check_vec("flush_valid", {31'd0, ID_EX_VALID}, 32'd0);
      EX_FLUSH = 1'b0;

      // format sweep
      drive(SW_M1, 32'h500, 1'b1);
      tick();
      check_vec("sw_imm", ID_EX_IMM, 32'hFFFF_FFFF);
      check_vec("sw_ctl", {28'd0, ID_EX_VALID, ID_EX_REGWRITE, ID_EX_MEMREAD, ID_EX_MEMWRITE}, 32'b1001);
      drive(BEQ_M2, 32'h504, 1'b1);
      tick();
      check_vec("beq_imm", ID_EX_IMM, 32'hFFFF_FFFE);
      check_vec("beq_ctl", {28'd0, ID_EX_VALID, ID_EX_REGWRITE, ID_EX_MEMREAD, ID_EX_MEMWRITE}, 32'b1000);
      drive(LUI_F, 32'h508, 1'b1);
      tick();
      check_vec("lui_imm", ID_EX_IMM, 32'hFFFF_F000);
      check_vec("lui_regwrite", {31'd0, ID_EX_REGWRITE}, 32'd1);
      drive(JAL_M2, 32'h50C, 1'b1);
      tick();
      check_vec("jal_imm", ID_EX_IMM, 32'hFFFF_FFFE);
      check_vec("jal_regwrite", {31'd0, ID_EX_REGWRITE}, 32'd1);
      drive(ILLEGAL, 32'h510, 1'b1);
      tick();
      check_vec("ill_ctl", {29'd0, ID_EX_REGWRITE, ID_EX_MEMREAD, ID_EX_MEMWRITE}, 32'd0);
      check_vec("ill_imm", ID_EX_IMM, 32'd0);

      // empty decode slot
      drive(ADDI, 32'h600, 1'b0);
      tick();
      check_vec("novalid_bubble", {31'd0, ID_EX_VALID}, 32'd0);

      // asynchronous reset mid-stream with a load sitting in ID/EX
      drive(LW, 32'h700, 1'b1);
      tick();
      drive(ADD_DEP, 32'h704, 1'b1);
      check_vec("pre_rst_stall", {31'd0, STALL}, 32'd1);
      #1;
      RST = 1'b1;
      #1;
      check_all_zero("midrst");
      tick();
      #1;
      RST = 1'b0;
      #1;
      check_vec("post_rst_stall", {31'd0, STALL}, 32'd0);
      tick();
      check_vec("post_rst_valid", {31'd0, ID_EX_VALID}, 32'd1);
      check_vec("post_rst_pc", ID_EX_PC, 32'h704);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-side pipeline stage of the pipelined OTTER core. It takes the instruction held in IF/ID and drives the register file read addresses. It bypasses same-cycle writeback data around the register file, generates the immediate and control bits, and detects load-use hazards. Results are registered into the ID/EX pipeline register consumed by the execute stage.

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers.
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset; asynchronous, active-high.
- IF_ID_INSTR  in  32  instruction in decode.
- IF_ID_PC  in  32  PC of that instruction.
- IF_ID_VALID  in  1  decode slot holds a real instruction.
- RD1, RD2  in  32  register file read data for A1/A2.
- WB_WE  in  1  writeback write enable (same signal driving register file WE3).
- WB_RD  in  5  writeback destination (register file A3).
- WB_DATA  in  32  writeback data (register file WD3).
- EX_FLUSH  in  1  taken branch/jump in EX; kills the decode instruction.
- A1, A2  out  5  combinational: IF_ID_INSTR[19:15], IF_ID_INSTR[24:20].
- STALL  out  1  combinational: hold PC and IF/ID this cycle.
- ID_EX_VALID  out  1  registered.
- ID_EX_PC, ID_EX_RS1_DATA, ID_EX_RS2_DATA, ID_EX_IMM  out  32  registered.
- ID_EX_RS1, ID_EX_RS2, ID_EX_RD  out  5  registered.
- ID_EX_OPCODE  out  7; ID_EX_FUNCT3  out  3; ID_EX_FUNCT7B5  out  1  registered.
- ID_EX_REGWRITE, ID_EX_MEMREAD, ID_EX_MEMWRITE  out  1  registered.

## Operation
- Decode fields: rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0], funct3=[14:12], funct7b5=[30].
- Formats:
  - I: opcodes 0010011, 0000011, 1100111.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111. R: 0110011.
  - Any other opcode is illegal: it enters EX with all control bits 0.
- Immediates use standard RV32I sign extension from bit 31; R and illegal give 0.
- Control:
  - REGWRITE = 1 for R/I/U/J formats.
  - MEMREAD = 1 for opcode 0000011 only.
  - MEMWRITE = 1 for opcode 0100011 only.
  - uses_rs1 is true for R/I/S/B formats.
  - uses_rs2 is true for R/S/B formats.
- Bypass: operand n uses WB_DATA when WB_WE && WB_RD != 0 && WB_RD == rsn; otherwise it uses RDn. Register x0 always reads 0 regardless of bypass.
- Load-use hazard, all conditions required:
  - ID_EX_VALID && ID_EX_MEMREAD && ID_EX_RD != 0 && IF_ID_VALID;
  - and either (uses_rs1 && ID_EX_RD == rs1) or (uses_rs2 && ID_EX_RD == rs2).
- STALL = hazard && !EX_FLUSH.
- Register update priority:
  1. RST: all outputs cleared.
  2. EX_FLUSH: bubble.
  3. hazard: bubble.
  4. !IF_ID_VALID: bubble.
  5. Otherwise load the decoded instruction.
- A bubble sets ID_EX_VALID, REGWRITE, MEMREAD and MEMWRITE to 0. Data fields may hold any value but are driven to 0.

## Timing
- Reset: every registered output is 0 from the RST assertion edge, asynchronously. STALL is 0 while RST is high.
- Latency: decode to ID/EX is one cycle. An instruction present at edge k appears on ID_EX_* after edge k.
- A1/A2/STALL are pure combinational functions of the current inputs and state. There is no registered delay.
- Load-use: exactly one bubble per hazard. On the following cycle the load has left ID/EX, so the hazard clears and the held instruction issues.
- Simultaneous writeback and read of the same register in decode: the bypassed value is captured. The register file's posedge write is not visible in time.
- EX_FLUSH with hazard: bubble, STALL=0. The IF/ID flush is external.
- RST deasserted mid-stream: the first valid instruction issues with no spurious stall, because the cleared ID_EX_VALID blocks the hazard.

## Test plan
- Reset: assert RST mid-run. Every ID_EX_* is 0 immediately without a clock edge, and STALL=0.
- Decode: addi x5,x1,-4 (0xFFC08293) with RD1=10 → next cycle ID_EX_IMM=0xFFFFFFFC, RD=5, RS1_DATA=10, REGWRITE=1.
- Bypass: decode add x3,x1,x2 while WB_WE=1, WB_RD=1, WB_DATA=0xDEADBEEF, RD1=0 → ID_EX_RS1_DATA=0xDEADBEEF. With WB_RD=0 instead, the value comes from RD1.
- Load-use:
  - lw x7,0(x2) then add x8,x7,x1 → STALL=1 for one cycle, then one bubble (ID_EX_VALID=0), then the add issues.
  - With add x8,x1,x1 instead → no stall.
- Flush during hazard: the lw/add pair as above with EX_FLUSH=1 in the hazard cycle → STALL=0, ID_EX_VALID=0.
- Format sweep: sw, beq, lui and jal with all-ones immediate fields → correct sign-extended immediates. sw/beq give REGWRITE=0; an illegal opcode gives all control bits 0.
